// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port arbiter for a shared image ROM with tagged, in-order read returns.
// Define ROM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module rom_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [15:0]       stall0_cnt
);
  logic [ADDR_W-1:0] addr_q;
  logic [ROM_LAT-1:0] tag_v;
  logic [ROM_LAT-1:0] tag_p;
  logic win1;
`ifdef ROM_ARB_RR_EN
  logic rr_ptr;
  always_ff @(posedge pclk)
    if (!rst) rr_ptr <= 1'b0;
    else if (gnt0 || gnt1) rr_ptr <= gnt0;
  assign win1 = rr_ptr;
`else
  assign win1 = 1'b0;
`endif
  always_comb begin
    gnt0 = rst && req0 && (!req1 || !win1);
    gnt1 = rst && req1 && (!req0 || win1);
    rom_addr = gnt0 ? addr0 : gnt1 ? addr1 : addr_q;
  end
  // tag exits stage ROM_LAT-1 in the same cycle its ROM data is on rom_data
  always_ff @(posedge pclk) begin
    if (!rst) begin
      addr_q <= '0;
      tag_v <= '0;
      tag_p <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      stall0_cnt <= '0;
    end else begin
      addr_q <= rom_addr;
      tag_v[0] <= gnt0 || gnt1;
      tag_p[0] <= gnt1;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
      rvalid0 <= tag_v[ROM_LAT-1] && !tag_p[ROM_LAT-1];
      rvalid1 <= tag_v[ROM_LAT-1] && tag_p[ROM_LAT-1];
      if (tag_v[ROM_LAT-1] && !tag_p[ROM_LAT-1]) rdata0 <= rom_data;
      if (tag_v[ROM_LAT-1] && tag_p[ROM_LAT-1]) rdata1 <= rom_data;
      if (req0 && !gnt0 && stall0_cnt != 16'hFFFF) stall0_cnt <= stall0_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: randomized check of rom_arbiter at ROM_LAT=1 and ROM_LAT=3 against a queue-based model.
module tb_rom_arbiter;
`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    int         due;
    bit         port;
    logic [11:0] data;
  } resp_t;
  logic pclk = 1'b0;
  logic rst = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic [11:0] addr0 = '0;
  logic [11:0] addr1 = '0;
  logic gnt0_o [2];
  logic gnt1_o [2];
  logic rvalid0_o [2];
  logic rvalid1_o [2];
  logic [11:0] rdata0_o [2];
  logic [11:0] rdata1_o [2];
  logic [11:0] rom_addr_o [2];
  logic [11:0] rom_data_i [2];
  logic [15:0] stall0_o [2];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int lat [2] = '{1, 3};
  resp_t exp_q [2][$];
  logic [11:0] rd_exp [2][2];
  bit fav;
  int stall;
  logic [11:0] hold_addr;
  bit acc0, acc1;
  always #5 pclk = ~pclk;
  function automatic logic [11:0] rom_fn(logic [11:0] a);
    return (a * 12'd2533) ^ 12'h3C7;
  endfunction
  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : 3;
    logic [11:0] pipe [L];
    always_ff @(posedge pclk) begin
      pipe[0] <= rom_fn(rom_addr_o[k]);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_data_i[k] = pipe[L-1];
    rom_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(L)) u_dut (
      .pclk(pclk), .rst(rst),
      .req0(req0), .addr0(addr0), .gnt0(gnt0_o[k]), .rdata0(rdata0_o[k]), .rvalid0(rvalid0_o[k]),
      .req1(req1), .addr1(addr1), .gnt1(gnt1_o[k]), .rdata1(rdata1_o[k]), .rvalid1(rvalid1_o[k]),
      .rom_addr(rom_addr_o[k]), .rom_data(rom_data_i[k]), .stall0_cnt(stall0_o[k])
    );
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask
  function automatic void mclear();
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      rd_exp[k][0] = '0;
      rd_exp[k][1] = '0;
    end
    fav = 1'b0;
    stall = 0;
    hold_addr = '0;
    acc0 = 1'b0;
    acc1 = 1'b0;
  endfunction
  // one checked cycle: compare outputs at negedge, then advance the model across the next edge
  task automatic tick();
    int w;
    logic [11:0] a;
    bit rv0, rv1;
    resp_t r;
    @(negedge pclk);
    w = -1;
    if (rst && (req0 || req1)) w = (req0 && req1) ? (RR ? int'(fav) : 0) : (req1 ? 1 : 0);
    a = (w == 0) ? addr0 : (w == 1) ? addr1 : hold_addr;
    for (int k = 0; k < 2; k++) begin
      rv0 = 1'b0;
      rv1 = 1'b0;
      if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
        r = exp_q[k].pop_front();
        if (r.port) rv1 = 1'b1;
        else rv0 = 1'b1;
        rd_exp[k][r.port] = r.data;
      end
      check($sformatf("gnt[%0d]", k), {gnt1_o[k], gnt0_o[k]}, {w == 1, w == 0});
      check($sformatf("rom_addr[%0d]", k), rom_addr_o[k], a);
      check($sformatf("rvalid[%0d]", k), {rvalid1_o[k], rvalid0_o[k]}, {rv1, rv0});
      check($sformatf("rdata0[%0d]", k), rdata0_o[k], rd_exp[k][0]);
      check($sformatf("rdata1[%0d]", k), rdata1_o[k], rd_exp[k][1]);
      check($sformatf("stall0[%0d]", k), stall0_o[k], stall);
    end
    if (w >= 0) begin
      for (int k = 0; k < 2; k++) exp_q[k].push_back('{cyc + lat[k] + 1, w == 1, rom_fn(a)});
      if (RR) fav = (w == 0);
      hold_addr = a;
    end
    if (rst && req0 && w != 0 && stall < 65535) stall++;
    acc0 = (w == 0);
    acc1 = (w == 1);
    if (!rst) mclear();
    cyc++;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(posedge pclk);
    mclear();
  endtask
  task automatic step(bit r, bit q0, logic [11:0] a0, bit q1, logic [11:0] a1);
    @(posedge pclk);
    #1;
    rst = r;
    req0 = q0;
    addr0 = a0;
    req1 = q1;
    addr1 = a1;
    tick();
  endtask
  task automatic rand_steps(int n, int p0, int p1, int prst);
    repeat (n) begin
      @(posedge pclk);
      #1;
      rst = ($urandom_range(0, 999) >= prst);
      if (!req0 || acc0) begin
        req0 = ($urandom_range(0, 99) < p0);
        addr0 = 12'($urandom);
      end
      if (!req1 || acc1) begin
        req1 = ($urandom_range(0, 99) < p1);
        addr1 = 12'($urandom);
      end
      tick();
    end
  endtask
  initial begin
    do_reset();
    step(1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 12'h010 + 12'(i), 1'b0, 12'h0);
    repeat (5) step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0);
    repeat (5) step(1'b1, 1'b1, 12'h100, 1'b1, 12'h200);
    repeat (2) step(1'b1, 1'b0, 12'h100, 1'b1, 12'h200);
    repeat (5) step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0);
    rand_steps(3000, 60, 60, 0);
    rand_steps(500, 100, 100, 0);
    rand_steps(2000, 50, 50, 5);
    repeat (5) step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0);
    step(1'b1, 1'b1, 12'h055, 1'b0, 12'h0);
    step(1'b1, 1'b0, 12'h0, 1'b1, 12'h0AA);
    step(1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
    repeat (8) step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0);
    rand_steps(1000, 70, 40, 0);
`ifdef ROM_ARB_RR_EN
    do_reset();
    @(posedge pclk);
    #1;
    force g_dut[0].u_dut.rr_ptr = 1'b1;
    rst = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (70000) @(posedge pclk);
    @(negedge pclk);
    check("stall_sat", stall0_o[0], 16'hFFFF);
    release g_dut[0].u_dut.rr_ptr;
    do_reset();
    step(1'b0, 1'b0, 12'h0, 1'b0, 12'h0);
    rand_steps(300, 60, 60, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
